// File: rtl/mul_seq_r32m.sv
// mul_seq_r32m: iterative radix-2 shift-add multiplier for the RV32M
// MUL / MULH / MULHU / MULHSU group. Operands are reduced to magnitudes,
// multiplied over dataW shift-add steps, then sign-corrected in FIX.
// Optional build macro: MUL_SEQ_EARLY_EXIT_EN, which stops iterating once
// the remaining multiplier bits are all zero and applies the outstanding
// right shift in a single step.
module mul_seq_r32m #(
    parameter int dataW = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       mulCode,
    input  logic [dataW-1:0] A,
    input  logic [dataW-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [dataW-1:0] result
);

    localparam int CNT_W = $clog2(dataW) + 1;
    localparam logic [dataW-1:0]   ONE_W  = {{(dataW-1){1'b0}}, 1'b1};
    localparam logic [2*dataW-1:0] ONE_2W = {{(2*dataW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [1:0]         code_r;
    logic [dataW-1:0]   mcand_r;
    logic [dataW-1:0]   mplier_r;
    logic [2*dataW-1:0] acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_r;
    logic               busy_r;
    logic               done_r;
    logic [dataW-1:0]   result_r;

    logic               sign_a_s;
    logic               sign_b_s;
    logic [dataW-1:0]   abs_a_s;
    logic [dataW-1:0]   abs_b_s;
    logic [dataW:0]     addend_s;
    logic [dataW:0]     sum_s;
    logic [2*dataW-1:0] step_acc_s;
    logic [2*dataW-1:0] run_acc_s;
    logic [2*dataW-1:0] fixed_s;
    logic               last_iter_s;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    logic [CNT_W-1:0]   shift_s;
`endif

    // Operand magnitudes and sign selection for the request on the inputs.
    always_comb begin
        sign_a_s = ((mulCode == 2'd1) || (mulCode == 2'd3)) && A[dataW-1];
        sign_b_s = (mulCode == 2'd1) && B[dataW-1];
        if (sign_a_s) begin
            abs_a_s = ~A + ONE_W;
        end else begin
            abs_a_s = A;
        end
        if (sign_b_s) begin
            abs_b_s = ~B + ONE_W;
        end else begin
            abs_b_s = B;
        end
    end

    // One shift-add step, termination test and final sign correction.
    always_comb begin
        if (mplier_r[0]) begin
            addend_s = {1'b0, mcand_r};
        end else begin
            addend_s = {(dataW+1){1'b0}};
        end
        sum_s      = {1'b0, acc_r[2*dataW-1:dataW]} + addend_s;
        step_acc_s = {sum_s, acc_r[dataW-1:1]};
`ifdef MUL_SEQ_EARLY_EXIT_EN
        // Remaining steps would only shift zeros in, so collapse them.
        last_iter_s = (mplier_r[dataW-1:1] == {(dataW-1){1'b0}});
        shift_s     = CNT_W'(dataW - 1) - cnt_r;
        if (last_iter_s) begin
            run_acc_s = step_acc_s >> shift_s;
        end else begin
            run_acc_s = step_acc_s;
        end
`else
        last_iter_s = (cnt_r == CNT_W'(dataW - 1));
        run_acc_s   = step_acc_s;
`endif
        if (neg_r) begin
            fixed_s = ~acc_r + ONE_2W;
        end else begin
            fixed_s = acc_r;
        end
    end

    // Next-state selection; flush always returns to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !flush) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    next_state_s = ST_IDLE;
                end else if (last_iter_s) begin
                    next_state_s = ST_FIX;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath registers: latch on accept, iterate in RUN, correct in FIX.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            code_r   <= 2'd0;
            mcand_r  <= {dataW{1'b0}};
            mplier_r <= {dataW{1'b0}};
            acc_r    <= {(2*dataW){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            neg_r    <= 1'b0;
            result_r <= {dataW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (next_state_s == ST_RUN) begin
                        code_r   <= mulCode;
                        mcand_r  <= abs_a_s;
                        mplier_r <= abs_b_s;
                        neg_r    <= sign_a_s ^ sign_b_s;
                        acc_r    <= {(2*dataW){1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (!flush) begin
                        acc_r    <= run_acc_s;
                        mplier_r <= mplier_r >> 1;
                        cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        acc_r <= fixed_s;
                        if (code_r == 2'd0) begin
                            result_r <= fixed_s[dataW-1:0];
                        end else begin
                            result_r <= fixed_s[2*dataW-1:dataW];
                        end
                    end
                end
                ST_DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered handshake outputs derived from the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_RUN) || (next_state_s == ST_FIX);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_mul_seq_r32m.sv
// Scoreboard bench for mul_seq_r32m: the stimulus pushes the expected
// result and latency, a negedge monitor pops on every done pulse.
module tb_mul_seq_r32m;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [1:0]  mulCode;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    mul_seq_r32m #(.dataW(32)) dut (
        .clock(clock), .reset(reset), .start(start), .flush(flush),
        .mulCode(mulCode), .A(A), .B(B),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    // Reference: full-precision product of the operands as the instruction reads them.
    function automatic logic [31:0] ref_mul(input logic [1:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sbv;
        longint p;
        logic [63:0] pb;
        sa  = (code == 2'd1 || code == 2'd3) ? longint'($signed(a)) : longint'({32'h0, a});
        sbv = (code == 2'd1) ? longint'($signed(b)) : longint'({32'h0, b});
        p   = sa * sbv;
        pb  = p;
        return (code == 2'd0) ? pb[31:0] : pb[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] code, input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        logic [31:0] mag;
        int idx;
        mag = (code == 2'd1 && b[31]) ? (32'h0 - b) : b;
        idx = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) idx = i;
        return 3 + idx;
`else
        return 34;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor: pop and compare on every done pulse.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result 0x%0h with empty scoreboard", result);
            end else begin
                e = sb.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                chk("busy_cycles", 64'(busy_cnt), 64'(e.lat - 1));
                chk("busy_with_done", 64'(busy), 64'(0));
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen, got 0 expected 1");
        end
    endtask

    task automatic push_exp(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res       = ref_mul(code, a, b);
        e.start_cyc = cyc;
        e.lat       = exp_lat(code, b);
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; mulCode = code; A = a; B = b;
        push_exp(code, a, b);
        @(negedge clock);
        start = 1'b0; mulCode = 2'($urandom); A = $urandom; B = $urandom;
        wait_done();
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; flush = 1'b0; mulCode = 2'd0; A = 32'h0; B = 32'h0;
        repeat (2) @(negedge clock);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_result", 64'(result), 64'(0));
        reset = 1'b0;

        // Directed corner cases.
        issue(2'd0, 32'd7, 32'hFFFF_FFFD);
        issue(2'd1, 32'h8000_0000, 32'h8000_0000);
        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd0, 32'd3, 32'd0);

        // start held high with changing operands: only the first is taken.
        @(negedge clock);
        start = 1'b1; mulCode = 2'd0; A = 32'd3; B = 32'd5;
        push_exp(2'd0, 32'd3, 32'd5);
        n = 0;
        do begin
            @(negedge clock);
            if (!done) begin
                A = $urandom; B = $urandom; mulCode = 2'($urandom);
            end
            n++;
        end while (!done && n < 200);
        start = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout_b2b: done not seen, got 0 expected 1");
        end
        issue(2'd2, 32'd9, 32'd11);
        issue(2'd0, 32'd3, 32'd5);

        // start together with flush in IDLE is dropped.
        @(negedge clock);
        start = 1'b1; flush = 1'b1; A = 32'd100; B = 32'd100;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        chk("start_flush_idle_busy", 64'(busy), 64'(0));

        // flush in RUN cycle 10.
        @(negedge clock);
        start = 1'b1; mulCode = 2'd2; A = 32'hDEAD_BEEF; B = 32'hFFFF_FFFF;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        chk("busy_before_flush", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_done", 64'(done), 64'(0));
        repeat (40) @(negedge clock);
        chk("flush_result_kept", 64'(result), 64'(15));

        // Asynchronous reset mid-RUN.
        @(negedge clock);
        start = 1'b1; mulCode = 2'd0; A = 32'd77; B = 32'd99;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", 64'(busy), 64'(0));
        chk("async_reset_done", 64'(done), 64'(0));
        chk("async_reset_result", 64'(result), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        // Randomised sweep over all four operations.
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), rand_op(), rand_op());
        end

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
